// File: rtl/smi_pkg.sv
// Shared definitions for the SMI stream scheduler: FSM encoding, header
// nibble and channel indices.
package smi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4
    } smi_state_e;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    // Burst header byte: fixed nibble, three zero bits, channel index in bit0.
    function automatic logic [7:0] hdr_byte(input logic ch);
        return {HDR_NIBBLE, 3'b000, ch};
    endfunction

endpackage

// File: rtl/smi_rr_arb2.sv
// Two-way round-robin selector: when both channels are eligible the one not
// granted last wins, otherwise the single eligible channel wins.
module smi_rr_arb2
    import smi_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_ch
);

    // Pure combinational pick; no state lives here, "last" is held by the caller.
    always_comb begin
        grant_valid = |eligible;
        grant_ch    = CH_09;
        case (eligible)
            2'b01:   grant_ch = CH_09;
            2'b10:   grant_ch = CH_24;
            2'b11:   grant_ch = ~last;
            default: grant_ch = CH_09;
        endcase
    end

endmodule

// File: rtl/smi_stream_sched.sv
// Streams 32-bit words from two radio-channel FIFOs onto the byte-wide SMI
// bus, one header byte per grant followed by up to BURST_WORDS words sent
// MSB first.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an eligible channel; arbitration happens here
// HDR   | header byte presented, waiting for the host to take it
// FETCH | pop one word from the granted FIFO, or end the burst early
// LOAD  | popped word arrives; latch it and present its top byte
// SEND  | data byte presented, waiting for the host to take it
module smi_stream_sched
    import smi_pkg::*;
#(
    parameter int BURST_WORDS = 16
) (
    input  logic        i_sys_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_ch_enable,
    output logic        o_fifo_09_pull,
    input  logic [31:0] i_fifo_09_pulled_data,
    input  logic        i_fifo_09_empty,
    output logic        o_fifo_24_pull,
    input  logic [31:0] i_fifo_24_pulled_data,
    input  logic        i_fifo_24_empty,
    input  logic        i_smi_soe_se,
    output logic [7:0]  o_smi_data_out,
    output logic        o_smi_read_req,
    output logic        o_active_ch,
    output logic        o_busy,
    output logic        o_underrun
);

    localparam logic [7:0] BURST_LAST = 8'(BURST_WORDS);

    smi_state_e  state_q;
    logic        soe_prev_q;
    logic        last_q;
    logic        active_ch_q;
    logic [7:0]  word_cnt_q;
    logic [7:0]  word_cnt_d;
    logic [1:0]  byte_idx_q;
    logic [31:0] shreg_q;
    logic [7:0]  data_q;
    logic        read_req_q;
    logic        busy_q;
    logic        underrun_q;

    logic        strobe;
    logic [1:0]  eligible;
    logic        grant_valid;
    logic        grant_ch;
    logic        fetch_ok;
    logic [31:0] pulled_word;

    // Host takes a byte on the falling edge of its (already synchronised) read strobe.
    assign strobe = soe_prev_q & ~i_smi_soe_se;

    assign eligible = i_ch_enable & ~{i_fifo_24_empty, i_fifo_09_empty};

    smi_rr_arb2 u_arb (
        .eligible    (eligible),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_ch    (grant_ch)
    );

    // The granted channel may still continue only if it is enabled and has data;
    // checking the enable here is what ends a burst after its enable is dropped.
    always_comb begin
        fetch_ok    = 1'b0;
        pulled_word = i_fifo_09_pulled_data;
        if (active_ch_q == CH_24) begin
            fetch_ok    = i_ch_enable[1] & ~i_fifo_24_empty;
            pulled_word = i_fifo_24_pulled_data;
        end else begin
            fetch_ok    = i_ch_enable[0] & ~i_fifo_09_empty;
            pulled_word = i_fifo_09_pulled_data;
        end
    end

    // Pulls are decoded from the FETCH state against the live empty flag so a
    // pull can never coincide with empty; gating with reset keeps a word from
    // being popped on the very edge that resets the block.
    always_comb begin
        o_fifo_09_pull = 1'b0;
        o_fifo_24_pull = 1'b0;
        if (i_reset_n && state_q == ST_FETCH && fetch_ok) begin
            o_fifo_09_pull = (active_ch_q == CH_09);
            o_fifo_24_pull = (active_ch_q == CH_24);
        end
    end

    assign word_cnt_d = word_cnt_q + 8'd1;

    // Main sequencer with registered bus-facing outputs.
    always_ff @(posedge i_sys_clk) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            soe_prev_q  <= 1'b1;
            last_q      <= CH_24;
            active_ch_q <= CH_09;
            word_cnt_q  <= 8'd0;
            byte_idx_q  <= 2'd0;
            shreg_q     <= 32'd0;
            data_q      <= 8'h00;
            read_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            soe_prev_q <= i_smi_soe_se;

            // A read with nothing presented is flagged and otherwise ignored.
            if (strobe && !read_req_q) begin
                underrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_q     <= ST_HDR;
                        data_q      <= hdr_byte(grant_ch);
                        active_ch_q <= grant_ch;
                        last_q      <= grant_ch;
                        word_cnt_q  <= 8'd0;
                        read_req_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                ST_HDR: begin
                    if (strobe) begin
                        state_q    <= ST_FETCH;
                        read_req_q <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (fetch_ok) begin
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    shreg_q    <= pulled_word;
                    data_q     <= pulled_word[31:24];
                    byte_idx_q <= 2'd0;
                    read_req_q <= 1'b1;
                    state_q    <= ST_SEND;
                end

                ST_SEND: begin
                    if (strobe) begin
                        if (byte_idx_q != 2'd3) begin
                            data_q     <= shreg_q[23:16];
                            shreg_q    <= {shreg_q[23:0], 8'h00};
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end else begin
                            word_cnt_q <= word_cnt_d;
                            read_req_q <= 1'b0;
                            if (word_cnt_d == BURST_LAST) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    read_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_smi_data_out = data_q;
    assign o_smi_read_req = read_req_q;
    assign o_active_ch    = active_ch_q;
    assign o_busy         = busy_q;
    assign o_underrun     = underrun_q;

endmodule

// File: tb/tb_smi_stream_sched.sv
// Bench for smi_stream_sched: FIFO models feed the DUT, a host model reads
// bytes off the SMI bus and compares them against a scoreboard of expected
// bytes/channels pushed when the FIFO words are queued.
module tb_smi_stream_sched;

    localparam int BW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  en;
    logic        pull09, pull24;
    logic [31:0] d09, d24;
    logic        emp09, emp24;
    logic        soe;
    logic [7:0]  data;
    logic        req, act, busy, underrun;

    typedef struct packed {
        logic [7:0] b;
        logic       ch;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] q09[$];
    logic [31:0] q24[$];

    int errors = 0;
    int checks = 0;
    int pulls09 = 0;
    int pulls24 = 0;
    logic mon_no09 = 1'b0;

    always #5 clk = ~clk;

    smi_stream_sched #(.BURST_WORDS(BW)) dut (
        .i_sys_clk             (clk),
        .i_reset_n             (rst_n),
        .i_ch_enable           (en),
        .o_fifo_09_pull        (pull09),
        .i_fifo_09_pulled_data (d09),
        .i_fifo_09_empty       (emp09),
        .o_fifo_24_pull        (pull24),
        .i_fifo_24_pulled_data (d24),
        .i_fifo_24_empty       (emp24),
        .i_smi_soe_se          (soe),
        .o_smi_data_out        (data),
        .o_smi_read_req        (req),
        .o_active_ch           (act),
        .o_busy                (busy),
        .o_underrun            (underrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO models: data appears the cycle after the pull.
    always @(posedge clk) begin
        if (pull09) begin
            pulls09++;
            if (q09.size() > 0) d09 <= q09.pop_front();
            emp09 <= (q09.size() == 0);
        end
        if (pull24) begin
            pulls24++;
            if (q24.size() > 0) d24 <= q24.pop_front();
            emp24 <= (q24.size() == 0);
        end
    end

    // Pull legality watched whenever a pull is seen.
    always @(negedge clk) begin
        if (pull09 | pull24) begin
            chk("pull_excl", 32'(pull09 & pull24), 32'd0);
            chk("pull09_on_empty", 32'(pull09 & emp09), 32'd0);
            chk("pull24_on_empty", 32'(pull24 & emp24), 32'd0);
        end
        if (mon_no09) chk("no_pull09", 32'(pull09), 32'd0);
    end

    task automatic push09(input logic [31:0] w);
        q09.push_back(w);
        emp09 = 1'b0;
    endtask

    task automatic push24(input logic [31:0] w);
        q24.push_back(w);
        emp24 = 1'b0;
    endtask

    task automatic exp_hdr(input logic ch);
        exp_t e;
        e.b  = {4'hA, 3'b000, ch};
        e.ch = ch;
        sb.push_back(e);
    endtask

    task automatic exp_bytes(input logic [31:0] w, input logic ch, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b  = w[31 - 8*i -: 8];
            e.ch = ch;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_soe();
        soe = 1'b0;
        @(negedge clk);
        soe = 1'b1;
        @(negedge clk);
    endtask

    task automatic host_read(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!req && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!req) begin
                chk("read_req_timeout", 32'(req), 32'd1);
                return;
            end
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
                return;
            end
            e = sb.pop_front();
            chk("byte", 32'(data), 32'(e.b));
            chk("active_ch", 32'(act), 32'(e.ch));
            pulse_soe();
        end
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"},     32'(data),     32'd0);
        chk({tag, "_req"},      32'(req),      32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_active"},   32'(act),      32'd0);
        chk({tag, "_pull09"},   32'(pull09),   32'd0);
        chk({tag, "_pull24"},   32'(pull24),   32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int lat;
        int p0;
        soe   = 1'b1;
        en    = 2'b00;
        rst_n = 1'b0;
        emp09 = 1'b1;
        emp24 = 1'b1;
        d09   = 32'd0;
        d24   = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Read strobe with nothing presented.
        pulse_soe();
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("underrun_data", 32'(data), 32'd0);
        chk("underrun_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("underrun_clear", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word burst on 0.9 GHz, then round robin to 2.4 GHz.
        en = 2'b11;
        push09(32'h11223344);
        push09(32'h55667788);
        push24(32'hAABBCCDD);
        exp_hdr(1'b0);
        exp_bytes(32'h11223344, 1'b0, 4);
        exp_bytes(32'h55667788, 1'b0, 4);
        exp_hdr(1'b1);
        exp_bytes(32'hAABBCCDD, 1'b1, 4);
        host_read(1);
        lat = 0;
        while (!req && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hdr_to_data_latency", 32'(lat), 32'd1);
        host_read(13);
        wait_idle("burst1_idle");
        chk("sb_empty1", 32'(sb.size()), 32'd0);
        chk("no_underrun1", 32'(underrun), 32'd0);

        // Only 2.4 GHz enabled while both FIFOs hold data.
        mon_no09 = 1'b1;
        en = 2'b10;
        push09(32'h01020304);
        push24(32'h0A0B0C0D);
        push24(32'h0E0F1011);
        push24(32'h12131415);
        exp_hdr(1'b1);
        exp_bytes(32'h0A0B0C0D, 1'b1, 4);
        exp_bytes(32'h0E0F1011, 1'b1, 4);
        exp_hdr(1'b1);
        exp_bytes(32'h12131415, 1'b1, 4);
        host_read(14);
        wait_idle("ch24_only_idle");
        repeat (5) @(negedge clk);
        chk("ch24_only_stays_idle", 32'(busy), 32'd0);
        chk("q09_untouched", 32'(q09.size()), 32'd1);
        mon_no09 = 1'b0;

        // One word in a burst-capable grant: early end at FETCH.
        p0 = pulls09;
        en = 2'b01;
        exp_hdr(1'b0);
        exp_bytes(32'h01020304, 1'b0, 4);
        host_read(5);
        wait_idle("early_end_idle");
        chk("early_end_pulls", 32'(pulls09 - p0), 32'd1);
        chk("sb_empty2", 32'(sb.size()), 32'd0);

        // Reset while the third byte of a word is presented.
        en = 2'b11;
        push09(32'hC0C1C2C3);
        push09(32'hD0D1D2D3);
        exp_hdr(1'b0);
        exp_bytes(32'hC0C1C2C3, 1'b0, 2);
        host_read(3);
        chk("pre_reset_byte", 32'(data), 32'hC2);
        p0 = pulls09;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midburst_reset");
        chk("reset_no_pull", 32'(pulls09 - p0), 32'd0);
        push24(32'hAABB0011);
        rst_n = 1'b1;
        exp_hdr(1'b0);
        exp_bytes(32'hD0D1D2D3, 1'b0, 4);
        exp_hdr(1'b1);
        exp_bytes(32'hAABB0011, 1'b1, 4);
        host_read(10);
        wait_idle("post_reset_idle");
        chk("sb_empty3", 32'(sb.size()), 32'd0);
        chk("q09_drained", 32'(q09.size()), 32'd0);
        chk("pulls09_total", 32'(pulls09), 32'd5);
        chk("pulls24_total", 32'(pulls24), 32'd5);
        chk("no_underrun_end", 32'(underrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smi_stream_sched.md
SMI_STREAM_SCHED -- requirements
Module: smi_stream_sched

Interface
REQ-001 Parameter BURST_WORDS, default 16, is the maximum number of 32-bit words sent per channel grant; legal range is 1..255.
REQ-002 i_sys_clk  in  1  single system clock; all logic is on its rising edge.
REQ-003 i_reset_n  in  1  reset, synchronous and active-low.
REQ-004 i_ch_enable  in  2  per-channel enable; bit0 is the 0.9 GHz channel, bit1 is the 2.4 GHz channel.
REQ-005 o_fifo_09_pull  out  1  one-cycle pop strobe to the 0.9 GHz FIFO.
REQ-006 i_fifo_09_pulled_data  in  32  0.9 GHz FIFO data, valid on the cycle after the pull.
REQ-007 i_fifo_09_empty  in  1  0.9 GHz FIFO empty flag.
REQ-008 o_fifo_24_pull  out  1  one-cycle pop strobe to the 2.4 GHz FIFO.
REQ-009 i_fifo_24_pulled_data  in  32  2.4 GHz FIFO data, valid on the cycle after the pull.
REQ-010 i_fifo_24_empty  in  1  2.4 GHz FIFO empty flag.
REQ-011 i_smi_soe_se  in  1  SMI read strobe, already synchronised to i_sys_clk.
REQ-012 o_smi_data_out  out  8  byte presented to the SMI bus.
REQ-013 o_smi_read_req  out  1  high while an unconsumed byte is presented.
REQ-014 o_active_ch  out  1  channel of the current or most recent grant (0 = 0.9 GHz, 1 = 2.4 GHz).
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_underrun  out  1  sticky flag for a host read with no byte pending.

Function
REQ-017 A byte strobe SHALL be a cycle where i_smi_soe_se is 0 and its registered previous value is 1; the registered value resets to 1.
REQ-018 The FSM SHALL have exactly these states: IDLE, HDR, FETCH, LOAD, SEND.
REQ-019 IDLE, channel selection:
- eligible = i_ch_enable & ~{i_fifo_24_empty, i_fifo_09_empty}.
- If both are eligible, grant the channel not granted last.
- If one is eligible, grant it.
- If none is eligible, stay in IDLE.
REQ-020 IDLE, on a grant: load o_smi_data_out with header {4'hA, 3'b000, ch}, set o_active_ch to ch, clear the word counter, go to HDR.
REQ-021 HDR: on a byte strobe go to FETCH; otherwise hold.
REQ-022 FETCH, granted FIFO non-empty and channel enabled: assert that FIFO's pull for exactly one cycle, then go to LOAD.
REQ-023 FETCH, otherwise: go to IDLE with no pull (early burst end).
REQ-024 LOAD: capture the pulled word into a 32-bit shift register, drive bits [31:24] on o_smi_data_out, set byte index to 0, go to SEND.
REQ-025 SEND, on a byte strobe with byte index < 3: present the next byte (MSB first) and increment the index.
REQ-026 SEND, on a byte strobe with byte index = 3: increment the word counter.
- If the counter reaches BURST_WORDS, go to IDLE.
- Otherwise go to FETCH.
REQ-027 o_smi_read_req SHALL be 1 in HDR and SEND and 0 in IDLE, FETCH and LOAD.
REQ-028 A byte strobe while o_smi_read_req is 0 SHALL set o_underrun and leave o_smi_data_out and the state unchanged.
REQ-029 o_fifo_09_pull and o_fifo_24_pull SHALL never be high in the same cycle, and neither SHALL be asserted while its empty flag is high.
REQ-030 Clearing a channel's enable mid-burst SHALL let the current word finish; the burst then ends at the next FETCH.
REQ-031 The word counter width SHALL be 8 bits; "last granted" updates on every grant.
REQ-032 Latency from a grant in IDLE to the first data byte presented SHALL be: header strobe + 2 cycles (FETCH, LOAD).

Reset
REQ-033 With i_reset_n low at a clock edge, the block SHALL reset as follows, overriding any state including mid-burst:
- state IDLE
- o_smi_data_out 8'h00
- o_smi_read_req, both pulls, o_busy, o_underrun: 0
- o_active_ch 0, last granted 1 (so 0.9 GHz wins first)
- counters 0
REQ-034 A word already pulled but not fully sent at reset SHALL be discarded with no re-pull.

Structure
REQ-035 The state encoding, header nibble 4'hA and the channel index constants SHALL live in the shared package smi_pkg.
REQ-036 The round-robin channel selection SHALL be one combinational sub-module, smi_rr_arb2 (inputs: eligible[1:0], last; outputs: grant_valid, grant_ch).

Verification
REQ-037 BURST_WORDS=2, enable=2'b11, 09 FIFO holds 0x11223344 and 0x55667788, 24 FIFO holds 0xAABBCCDD -> bytes A0 11 22 33 44 55 66 77 88, then A1 AA BB CC DD.
REQ-038 enable=2'b10, both FIFOs non-empty -> only 0xA1 headers appear, and o_fifo_09_pull stays 0.
REQ-039 BURST_WORDS=4, 09 FIFO holds 1 word -> header + 4 bytes, then FETCH sees empty, goes to IDLE with no pull, o_busy drops.
REQ-040 Strobe while IDLE -> o_underrun=1, o_smi_data_out unchanged, and it stays 1 until reset.
REQ-041 i_reset_n low for one cycle during SEND byte 2 -> next cycle shows all REQ-033 values and no pull, and the next grant is to channel 0.
